i2c_master_wr: RTL and testbench

- Write-only I2C master that consumes CPU stores steered to it by the bus address decoder (its write-enable is the decoder's I2C write strobe).
- Each accepted store triggers one full frame on the bus: START, 7-bit slave address with W, ACK, one data byte, ACK, STOP.
- Status is exported on a 32-bit read word for the core's load-data mux.

---
 rtl/i2c_pkg.sv | 41 ++++
 rtl/i2c_master_wr_if.sv | 24 ++
 rtl/i2c_tick_gen.sv | 27 ++
 rtl/i2c_master_wr.sv | 121 ++++++++++++
 tb/tb_i2c_master_wr.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, decoder address, status bit map and pin drive table.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ACK1,
        DATA,
        ACK2,
        STOP
    } state_t;

    localparam int unsigned I2C_ADDR    = 60;
    localparam int          STAT_BUSY   = 0;
    localparam int          STAT_ACKERR = 1;
    localparam int          STAT_DONE   = 2;

    // {scl, sda_oe} for a given phase and quarter; b is the bit being sent
    function automatic logic [1:0] phase_drive(state_t st, logic [1:0] q, logic b);
        logic [1:0] d;
        d = 2'b10;
        case (st)
            START:      d = (q == 2'd3) ? 2'b01 : {1'b1, q[1]};
            ADDR, DATA: d = {q[1], ~b};
            ACK1, ACK2: d = {q[1], 1'b0};
            STOP: begin
                case (q)
                    2'd0:    d = 2'b01;
                    2'd1:    d = 2'b11;
                    default: d = 2'b10;
                endcase
            end
            default:    d = 2'b10;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/i2c_master_wr_if.sv
// CPU-side store/status and I2C pin bundle for the write-only master.
// Latency: n/a (wires only).
// Backpressure: none; the CPU polls busy/done through rdata.
interface i2c_master_wr_if;
    logic        we;
    logic [31:0] wdata;
    logic        sda_in;
    logic        scl;
    logic        sda_oe;
    logic        busy;
    logic        ack_err;
    logic        done;
    logic [31:0] rdata;

    modport master (
        input  we, wdata, sda_in,
        output scl, sda_oe, busy, ack_err, done, rdata
    );

    modport slave (
        output we, wdata, sda_in,
        input  scl, sda_oe, busy, ack_err, done, rdata
    );
endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-period divider: counts 0..CLK_DIV-1 while enabled, 1-clock tick on the last count.
// Latency: tick every CLK_DIV enabled clocks, first one CLK_DIV clocks after clear.
// Backpressure: none; clr forces the count back to zero.
module i2c_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int           W    = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = en && !clr && (cnt == LAST);
endmodule

// File: rtl/i2c_master_wr.sv
// Write-only I2C master: one store -> START, addr+W, ACK, data byte, ACK, STOP.
// Latency: busy for 80*CLK_DIV clocks (44*CLK_DIV on address NACK) from the edge after we.
// Backpressure: stores arriving while busy are dropped; status readable every cycle.
module i2c_master_wr
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic           clk,
    input  logic           rst,
    i2c_master_wr_if.master bus
);
    state_t     state, ns;
    logic [1:0] q, nq;
    logic [2:0] bitcnt, nbit;
    logic [6:0] addr_r;
    logic [7:0] data_r;
    logic       nack_r;
    logic       tick;
    logic       scl_r, sda_oe_r, busy_r, ack_err_r, done_r;
    logic [7:0] nbyte;
    logic       nb;
    logic       accept;
    logic       ack_slot;
    logic       unused_wdata;

    assign unused_wdata = ^bus.wdata[31:15];

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .clr  (state == IDLE),
        .tick (tick)
    );

    assign accept   = (state == IDLE) && bus.we;
    assign ack_slot = (state == ACK1) || (state == ACK2);

    always_comb begin
        ns   = state;
        nq   = q;
        nbit = bitcnt;
        if (accept) begin
            ns   = START;
            nq   = 2'd0;
            nbit = 3'd0;
        end else if (tick) begin
            nq = q + 2'd1;
            if (q == 2'd3) begin
                case (state)
                    START: begin ns = ADDR; nbit = 3'd0; end
                    ADDR: begin
                        if (bitcnt == 3'd7) begin ns = ACK1; nbit = 3'd0; end
                        else                nbit = bitcnt + 3'd1;
                    end
                    // nack_r was captured at the end of q2 of this slot
                    ACK1:  begin ns = nack_r ? STOP : DATA; nbit = 3'd0; end
                    DATA: begin
                        if (bitcnt == 3'd7) begin ns = ACK2; nbit = 3'd0; end
                        else                nbit = bitcnt + 3'd1;
                    end
                    ACK2:    ns = STOP;
                    default: ns = IDLE;
                endcase
            end
        end
        nbyte = (ns == ADDR) ? {addr_r, 1'b0} : data_r;
        nb    = nbyte[3'd7 - nbit];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            q         <= 2'd0;
            bitcnt    <= 3'd0;
            addr_r    <= 7'd0;
            data_r    <= 8'd0;
            nack_r    <= 1'b0;
            scl_r     <= 1'b1;
            sda_oe_r  <= 1'b0;
            busy_r    <= 1'b0;
            ack_err_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state                <= ns;
            q                    <= nq;
            bitcnt               <= nbit;
            {scl_r, sda_oe_r}    <= phase_drive(ns, nq, nb);
            if (accept) begin
                addr_r    <= bus.wdata[14:8];
                data_r    <= bus.wdata[7:0];
                nack_r    <= 1'b0;
                busy_r    <= 1'b1;
                done_r    <= 1'b0;
                ack_err_r <= 1'b0;
            end
            if (tick && ack_slot && (q == 2'd2)) begin
                nack_r <= bus.sda_in;
                if (bus.sda_in) ack_err_r <= 1'b1;
            end
            if (tick && (state == STOP) && (q == 2'd3)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
        end
    end

    assign bus.scl     = scl_r;
    assign bus.sda_oe  = sda_oe_r;
    assign bus.busy    = busy_r;
    assign bus.ack_err = ack_err_r;
    assign bus.done    = done_r;

    always_comb begin
        bus.rdata              = 32'd0;
        bus.rdata[STAT_BUSY]   = busy_r;
        bus.rdata[STAT_ACKERR] = ack_err_r;
        bus.rdata[STAT_DONE]   = done_r;
    end
endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: stimulus queues expected bytes/STOPs/frames, a bus monitor decodes
// SDA at SCL rises and checks them; a slave model supplies ACK/NACK.
module tb_i2c_master_wr;

    localparam int CLK_DIV = 4;
    localparam int K_BYTE  = 0;
    localparam int K_STOP  = 1;
    localparam int K_FRAME = 2;

    typedef struct packed {
        int kind;
        int val;
        int val2;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pull = 1'b0;
    logic sda_line;
    logic nack_addr = 1'b0;
    logic nack_data = 1'b0;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    i2c_master_wr_if bus();

    i2c_master_wr #(.CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign sda_line   = !(bus.sda_oe || pull);
    assign bus.sda_in = sda_line;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input int val, input int val2);
        exp_q.push_back('{kind: kind, val: val, val2: val2});
    endtask

    task automatic pop_check(input int kind, input int val, input int val2, input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected event value 0x%0h, required none", name, val);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, kind, e.kind);
            chk({name, "_val"}, val, e.val);
            if (kind == K_FRAME) chk({name, "_rdata"}, val2, e.val2);
        end
    endtask

    // slave: pulls SDA during the 9th bit of each byte when configured to ACK
    int   s_rc = 0;
    int   s_bi = 0;
    logic s_pscl = 1'b1, s_pline = 1'b1;
    always @(negedge clk) begin
        if (rst) begin
            pull = 1'b0; s_rc = 0; s_bi = 0; s_pscl = 1'b1; s_pline = 1'b1;
        end else begin
            if (bus.scl && s_pscl && s_pline && !sda_line) begin
                s_rc = 0; s_bi = 0; pull = 1'b0;
            end else if (bus.scl && !s_pscl) begin
                s_rc++;
            end else if (!bus.scl && s_pscl) begin
                if (s_rc == 8) pull = (s_bi == 0) ? !nack_addr : !nack_data;
                else if (s_rc == 9) begin pull = 1'b0; s_rc = 0; s_bi++; end
            end
            s_pscl  = bus.scl;
            s_pline = sda_line;
        end
    end

    // monitor: decodes bytes, STOP conditions and busy windows
    int         m_rc = 0;
    int         m_bcnt = 0;
    logic       m_pbusy = 1'b0, m_pscl = 1'b1, m_pline = 1'b1;
    logic [7:0] m_sh = 8'd0;
    always @(negedge clk) begin
        if (rst) begin
            m_rc = 0; m_bcnt = 0; m_pbusy = 1'b0; m_pscl = 1'b1; m_pline = 1'b1;
        end else begin
            if (bus.scl && m_pscl && m_pline && !sda_line) begin
                m_rc = 0;
            end else if (bus.scl && m_pscl && !m_pline && sda_line) begin
                pop_check(K_STOP, 0, 0, "stop");
            end else if (bus.scl && !m_pscl) begin
                if (m_rc < 8) begin
                    m_sh = {m_sh[6:0], sda_line};
                    m_rc++;
                    if (m_rc == 8) pop_check(K_BYTE, int'(m_sh), 0, "byte");
                end else begin
                    m_rc = 0;
                end
            end
            if (bus.busy) m_bcnt++;
            else if (m_pbusy) begin
                pop_check(K_FRAME, m_bcnt, int'(bus.rdata), "frame");
                m_bcnt = 0;
            end
            m_pbusy = bus.busy;
            m_pscl  = bus.scl;
            m_pline = sda_line;
        end
    end

    task automatic drive_we(input logic [31:0] w);
        bus.we = 1'b1;
        bus.wdata = w;
        @(posedge clk); #1;
        bus.we = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        @(posedge clk); #1;
        drive_we(w);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", int'(bus.busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.we = 1'b0;
        bus.wdata = 32'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_scl", int'(bus.scl), 1);
        chk("rst_sda_oe", int'(bus.sda_oe), 0);
        chk("rst_rdata", int'(bus.rdata), 32'h0);
        rst = 1'b0;

        // full write, both ACKed
        nack_addr = 1'b0; nack_data = 1'b0;
        push(K_BYTE, 'h78, 0); push(K_BYTE, 'hA5, 0); push(K_STOP, 0, 0);
        push(K_FRAME, 80 * CLK_DIV, 32'h4);
        send(32'h0000_3CA5);
        wait_idle();

        // address NACK: no data byte
        nack_addr = 1'b1;
        push(K_BYTE, 'h22, 0); push(K_STOP, 0, 0);
        push(K_FRAME, 44 * CLK_DIV, 32'h6);
        send(32'h0000_1155);
        wait_idle();

        // data NACK, then a back-to-back ACKed frame in the first IDLE cycle
        nack_addr = 1'b0; nack_data = 1'b1;
        push(K_BYTE, 'h78, 0); push(K_BYTE, 'h0F, 0); push(K_STOP, 0, 0);
        push(K_FRAME, 80 * CLK_DIV, 32'h6);
        send(32'h0000_3C0F);
        wait_idle();
        chk("dnack_ack_err", int'(bus.ack_err), 1);
        chk("dnack_done", int'(bus.done), 1);
        nack_data = 1'b0;
        push(K_BYTE, 'h78, 0); push(K_BYTE, 'hA5, 0); push(K_STOP, 0, 0);
        push(K_FRAME, 80 * CLK_DIV, 32'h4);
        drive_we(32'h0000_3CA5);
        chk("b2b_busy", int'(bus.busy), 1);
        wait_idle();

        // store while busy is dropped
        push(K_BYTE, 'h78, 0); push(K_BYTE, 'hA5, 0); push(K_STOP, 0, 0);
        push(K_FRAME, 80 * CLK_DIV, 32'h4);
        send(32'h0000_3CA5);
        repeat (100) @(posedge clk);
        #1;
        drive_we(32'h0000_7FFF);
        wait_idle();
        repeat (400) @(posedge clk);
        #1;
        chk("wwb_no_second_busy", int'(bus.busy), 0);
        chk("wwb_queue_empty", exp_q.size(), 0);

        // reset during DATA phase
        push(K_BYTE, 'h78, 0);
        send(32'h0000_3CA5);
        repeat (200) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_scl", int'(bus.scl), 1);
        chk("mrst_sda_oe", int'(bus.sda_oe), 0);
        chk("mrst_busy", int'(bus.busy), 0);
        push(K_BYTE, 'h78, 0); push(K_BYTE, 'hA5, 0); push(K_STOP, 0, 0);
        push(K_FRAME, 80 * CLK_DIV, 32'h4);
        repeat (5) @(posedge clk);
        send(32'h0000_3CA5);
        wait_idle();
        repeat (20) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
